// File: rtl/bin_to_bcd_sampler.sv
// bin_to_bcd_sampler: samples a binary reading, converts it to 3 BCD digits by double dabble and
// presents the newest (cur) and previous (prev) results. Optional macro SAMPLE_QUEUE_EN adds a
// one-deep, last-wins request buffer for samples that arrive while busy.
module bin_to_bcd_sampler #(
  parameter int DIN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic [DIN_W-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  output logic [3:0]       cur_ones,
  output logic [3:0]       cur_tens,
  output logic [3:0]       cur_huns,
  output logic [3:0]       prev_ones,
  output logic [3:0]       prev_tens,
  output logic [3:0]       prev_huns
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [11:0] scr, scr_adj, cur, prev;
  logic [DIN_W-1:0] bin, load_val;
  logic [12+DIN_W-1:0] shifted;
  logic [9:0] din_x, din_sat;
  logic sat, ovf_p, seen_one, load, load_ovf;
  assign din_x = 10'(din);
  assign sat = din_x > 10'd999;
  assign din_sat = sat ? 10'd999 : din_x;
  assign busy = state != IDLE;
`ifdef SAMPLE_QUEUE_EN
  logic q_pend, q_ovf;
  logic [DIN_W-1:0] q_val;
  // Hold the latest request seen while busy; a request on the DONE edge is consumed directly.
  always_ff @(posedge clk)
    if (!rst_n) begin
      q_pend <= 1'b0;
      q_ovf <= 1'b0;
      q_val <= '0;
    end else if (state == DONE) q_pend <= 1'b0;
    else if (busy && sample) begin
      q_pend <= 1'b1;
      q_ovf <= sat;
      q_val <= DIN_W'(din_sat);
    end
  assign load = (state == IDLE && sample) || (state == DONE && (q_pend || sample));
  assign load_val = sample ? DIN_W'(din_sat) : q_val;
  assign load_ovf = sample ? sat : q_ovf;
`else
  assign load = state == IDLE && sample;
  assign load_val = DIN_W'(din_sat);
  assign load_ovf = sat;
`endif
  assign scr_adj = {scr[11:8] >= 4'd5 ? scr[11:8] + 4'd3 : scr[11:8],
                    scr[7:4]  >= 4'd5 ? scr[7:4]  + 4'd3 : scr[7:4],
                    scr[3:0]  >= 4'd5 ? scr[3:0]  + 4'd3 : scr[3:0]};
  assign shifted = {scr_adj, bin} << 1;
  // State register.
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state: start on a request, finish after DIN_W shifts, publish for one cycle.
  always_comb begin
    state_nx = state;
    state_nx = load ? SHIFT : (state == SHIFT && cnt == 4'd1) ? DONE : (state == DONE) ? IDLE : state;
  end
  // Conversion datapath: load the saturated reading, then add-3 and shift once per cycle.
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      scr <= '0;
      bin <= '0;
      ovf_p <= 1'b0;
    end else if (load) begin
      cnt <= 4'(DIN_W);
      scr <= '0;
      bin <= load_val;
      ovf_p <= load_ovf;
    end else if (state == SHIFT) begin
      {scr, bin} <= shifted;
      cnt <= cnt - 4'd1;
    end
  // Result registers: cur moves to prev and the finished digits become cur on the DONE edge.
  always_ff @(posedge clk)
    if (!rst_n) begin
      cur <= '0;
      prev <= '0;
      ovf <= 1'b0;
      valid <= 1'b0;
      done <= 1'b0;
      seen_one <= 1'b0;
    end else begin
      done <= state == DONE;
      if (state == DONE) begin
        prev <= cur;
        cur <= scr;
        ovf <= ovf_p;
        seen_one <= 1'b1;
        valid <= valid | seen_one;
      end
    end
  assign {cur_huns, cur_tens, cur_ones} = cur;
  assign {prev_huns, prev_tens, prev_ones} = prev;
endmodule

// File: tb/tb_bin_to_bcd_sampler.sv
// tb_bin_to_bcd_sampler: randomized and directed checks of bin_to_bcd_sampler against a decimal model.
module tb_bin_to_bcd_sampler;
  logic clk = 1'b0, rst_n = 1'b0, sample = 1'b0;
  logic [9:0] din = '0;
  logic busy, done, valid, ovf;
  logic [3:0] cur_ones, cur_tens, cur_huns, prev_ones, prev_tens, prev_huns;
  int n_tests = 0, n_fail = 0;
  int exp_cur = 0, exp_prev = 0, n_conv = 0, exp_ovf = 0;
  always #5 clk = ~clk;
  bin_to_bcd_sampler dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .din(din),
    .busy(busy), .done(done), .valid(valid), .ovf(ovf),
    .cur_ones(cur_ones), .cur_tens(cur_tens), .cur_huns(cur_huns),
    .prev_ones(prev_ones), .prev_tens(prev_tens), .prev_huns(prev_huns)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int bcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction
  task automatic model_reset();
    exp_cur = 0; exp_prev = 0; n_conv = 0; exp_ovf = 0;
  endtask
  task automatic complete(input int v);
    exp_prev = exp_cur;
    exp_cur = v > 999 ? 999 : v;
    exp_ovf = v > 999 ? 1 : 0;
    n_conv++;
  endtask
  task automatic check_state(input string tag);
    check({tag, ".cur"}, int'({cur_huns, cur_tens, cur_ones}), bcd(exp_cur));
    check({tag, ".prev"}, int'({prev_huns, prev_tens, prev_ones}), bcd(exp_prev));
    check({tag, ".valid"}, int'(valid), int'(n_conv >= 2));
    check({tag, ".ovf"}, int'(ovf), exp_ovf);
  endtask
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask
  task automatic convert(input int v);
    int k;
    @(negedge clk);
    sample = 1'b1;
    din = 10'(v);
    @(negedge clk);
    sample = 1'b0;
    din = 10'($urandom);
    check("busy_after_sample", int'(busy), 1);
    wait_done(0, k);
    check("latency", k, 11);
    complete(v);
    check_state("conv");
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("busy_idle", int'(busy), 0);
  endtask
  initial begin
    int k, n;
    int bounds[5] = '{0, 999, 1000, 1023, 7};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_state("reset");
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    count_done(20, n);
    check("idle_no_done", n, 0);
    convert(123);
    convert(456);
    foreach (bounds[i]) convert(bounds[i]);
    for (int i = 0; i < 16; i++) convert(int'($urandom_range(0, 1023)));
    @(negedge clk);
    sample = 1'b1;
    din = 10'd250;
    @(negedge clk);
    sample = 1'b0;
    repeat (3) @(negedge clk);
    sample = 1'b1;
    din = 10'd600;
    @(negedge clk);
    sample = 1'b0;
`ifdef SAMPLE_QUEUE_EN
    @(negedge clk);
    sample = 1'b1;
    din = 10'd777;
    @(negedge clk);
    sample = 1'b0;
    wait_done(6, k);
    check("queue.lat1", k, 11);
    complete(250);
    check_state("queue.first");
    check("queue.busy_held", int'(busy), 1);
    @(negedge clk);
    wait_done(1, k);
    check("queue.lat2", k, 11);
    complete(777);
    check_state("queue.second");
    @(negedge clk);
`else
    wait_done(4, k);
    check("ignore.lat", k, 11);
    complete(250);
    check_state("ignore");
    count_done(15, n);
    check("ignore.no_second_done", n, 0);
    sample = 1'b1;
    din = 10'd314;
    wait_done(0, k);
    check("hold.first_lat", k, 12);
    complete(314);
    check_state("hold.first");
    @(negedge clk);
    wait_done(1, k);
    check("hold.period", k, 12);
    sample = 1'b0;
    complete(314);
    check_state("hold.second");
    @(negedge clk);
`endif
    @(negedge clk);
    sample = 1'b1;
    din = 10'd888;
    @(negedge clk);
    sample = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_state("abort");
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(done), 0);
    count_done(15, n);
    check("abort.no_done", n, 0);
    convert(42);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
